// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM states and misalignment check for dmem_lsu
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    misaligned = addr_lo[0];
            SZ_W:    misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enable/data replication and load lane extraction/extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be        = 4'b0000;
        wdata_sh  = '0;
        rdata_ext = '0;
        rbyte     = rword[{addr_lo, 3'b000} +: 8];
        rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
        // Data is replicated across lanes so the byte-enable alone picks the target.
        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{~unsigned_ld & rbyte[7]}}, rbyte};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{~unsigned_ld & rhalf[15]}}, rhalf};
            end
            SZ_W: begin
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - handshaked byte/half/word data memory with wait states; DMEM_MISALIGN_TRAP_EN enables misalignment errors
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e          state;
    logic [3:0]      cnt;
    logic            l_write;
    logic [1:0]      l_size;
    logic            l_unsigned;
    logic [AW+1:0]   l_addr;
    logic [31:0]     l_wdata;

    logic            a_write;
    logic [1:0]      a_size;
    logic            a_unsigned;
    logic [AW+1:0]   a_addr;
    logic [31:0]     a_wdata;
    logic [AW-1:0]   widx;
    logic            bad;
    logic            do_access;
    logic            do_write;
    logic [3:0]      be;
    logic [31:0]     wdata_sh;
    logic [31:0]     rdata_ext;
    logic [31:0]     words [DEPTH];
    logic            unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    // Zero-wait accesses use the live request; delayed ones use the latched copy.
    always_comb begin
        a_write    = (state == S_IDLE) ? req_write      : l_write;
        a_size     = (state == S_IDLE) ? req_size       : l_size;
        a_unsigned = (state == S_IDLE) ? req_unsigned   : l_unsigned;
        a_addr     = (state == S_IDLE) ? req_addr[AW+1:0] : l_addr;
        a_wdata    = (state == S_IDLE) ? req_wdata      : l_wdata;
        widx       = a_addr[AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        bad        = (a_size == SZ_ILL) || misaligned(a_size, a_addr[1:0]);
`else
        bad        = (a_size == SZ_ILL);
`endif
        do_access  = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd1));
        do_write   = do_access && a_write && !bad;
    end

    dmem_lane_align u_align (
        .size        (a_size),
        .addr_lo     (a_addr[1:0]),
        .unsigned_ld (a_unsigned),
        .wdata       (a_wdata),
        .rword       (words[widx]),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    // Storage is deliberately outside the reset domain: contents survive reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [31:0] word = 32'(g);
        always_ff @(posedge clk) begin
            if (do_write && (widx == AW'(g))) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) word[8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
        assign words[g] = word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            l_write    <= 1'b0;
            l_size     <= SZ_B;
            l_unsigned <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
        end else begin
            if (do_access) begin
                rsp_rdata <= (a_write || bad) ? 32'd0 : rdata_ext;
                rsp_err   <= bad;
                rsp_valid <= 1'b1;
                state     <= S_RESP;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        l_write    <= req_write;
                        l_size     <= req_size;
                        l_unsigned <= req_unsigned;
                        l_addr     <= req_addr[AW+1:0];
                        l_wdata    <= req_wdata;
                        req_ready  <= 1'b0;
                        if (WAIT_CYCLES != 0) begin
                            cnt   <= 4'(WAIT_CYCLES);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd1) cnt <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed vector table, randomized model comparison and wait-state/reset sequences for dmem_lsu
module tb_dmem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_req_write, a_req_unsigned;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;

    logic        b_rst, b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;

    dmem_lsu #(.DEPTH(8), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .reset(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_size(a_req_size), .req_unsigned(a_req_unsigned),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid),
        .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_lsu #(.DEPTH(8), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .reset(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference memory viewed as a flat little-endian byte array.
    logic [7:0] mb [32];

    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] ad, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int n, base;
        logic [31:0] v;
        rd = 0;
        er = 0;
        if (sz == 2'b11) begin
            er = 1;
            return;
        end
        n    = 1 << sz;
        base = int'(ad[4:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (base % n != 0) begin
            er = 1;
            return;
        end
`endif
        base = base - base % n;
        if (w) begin
            for (int j = 0; j < n; j++) mb[base + j] = 8'(wd >> (8 * j));
        end else begin
            v = 0;
            for (int j = 0; j < n; j++) v = v | (32'(mb[base + j]) << (8 * j));
            if (!u && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] ad, input logic [31:0] wd,
                                input logic [31:0] erd, input logic eer);
        vec_t v;
        v.w = w; v.sz = sz; v.u = u; v.ad = ad; v.wd = wd; v.exp_rd = erd; v.exp_er = eer;
        tbl.push_back(v);
    endfunction

    task automatic xact_a(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int lat;
        check("a_ready_idle", 32'(a_req_ready), 32'd1);
        a_req_valid = 1; a_req_write = w; a_req_size = sz; a_req_unsigned = u;
        a_req_addr = ad; a_req_wdata = wd;
        @(posedge clk); #1;
        a_req_valid = 0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("a_latency", 32'(lat), 32'd1);
        rd = a_rsp_rdata;
        er = a_rsp_err;
        // Garbage request while the response is pending must be ignored.
        a_req_valid = 1; a_req_write = 1'($urandom); a_req_size = 2'($urandom);
        a_req_addr = $urandom; a_req_wdata = $urandom;
        @(posedge clk); #1;
        check("a_hold_valid", 32'(a_rsp_valid), 32'd1);
        check("a_hold_rdata", a_rsp_rdata, rd);
        check("a_hold_ready", 32'(a_req_ready), 32'd0);
        a_rsp_ready = 1;
        @(posedge clk); #1;
        a_rsp_ready = 0;
        a_req_valid = 0;
        check("a_rsp_done", 32'(a_rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;

        for (int k = 0; k < 32; k++) mb[k] = (k % 4 == 0) ? 8'(k / 4) : 8'h00;

        a_rst = 1; b_rst = 1;
        a_req_valid = 0; a_req_write = 0; a_req_size = 0; a_req_unsigned = 0;
        a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_size = 0; b_req_unsigned = 0;
        b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("a_rst_req_ready", 32'(a_req_ready), 32'd1);
        check("a_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("a_rst_rdata", a_rsp_rdata, 32'd0);
        check("a_rst_err", 32'(a_rsp_err), 32'd0);
        check("b_rst_req_ready", 32'(b_req_ready), 32'd1);
        check("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
        a_rst = 0; b_rst = 0;
        @(posedge clk); #1;

        add(0, 2'b10, 0, 32'h0C, 0, 32'h0000_0003, 0);
        add(1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 0, 0);
        add(0, 2'b00, 0, 32'h12, 0, 32'hFFFF_FFFF, 0);
        add(0, 2'b00, 1, 32'h12, 0, 32'h0000_00FF, 0);
        add(0, 2'b01, 0, 32'h12, 0, 32'hFFFF_80FF, 0);
        add(0, 2'b01, 1, 32'h12, 0, 32'h0000_80FF, 0);
        add(0, 2'b00, 0, 32'h11, 0, 32'h0000_007F, 0);
        add(1, 2'b00, 0, 32'h15, 32'h0000_00AB, 0, 0);
        add(0, 2'b10, 0, 32'h14, 0, 32'h0000_AB05, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add(0, 2'b10, 0, 32'h06, 0, 0, 1);
        add(1, 2'b10, 0, 32'h06, 32'hFFFF_FFFF, 0, 1);
        add(0, 2'b10, 0, 32'h04, 0, 32'h0000_0001, 0);
        add(0, 2'b01, 0, 32'h13, 0, 0, 1);
`else
        add(0, 2'b10, 0, 32'h06, 0, 32'h0000_0001, 0);
        add(1, 2'b10, 0, 32'h06, 32'hFFFF_FFFF, 0, 0);
        add(0, 2'b10, 0, 32'h04, 0, 32'hFFFF_FFFF, 0);
        add(0, 2'b01, 1, 32'h13, 0, 32'h0000_80FF, 0);
`endif
        add(0, 2'b10, 0, 32'h20, 0, 32'h0000_0000, 0);
        add(0, 2'b10, 0, 32'hFFFF_FFFC, 0, 32'h0000_0007, 0);
        add(0, 2'b11, 0, 32'h00, 0, 0, 1);
        add(1, 2'b11, 0, 32'h00, 32'h1234_5678, 0, 1);
        add(0, 2'b10, 0, 32'h00, 0, 32'h0000_0000, 0);
        add(1, 2'b01, 0, 32'h1A, 32'hCAFE_1234, 0, 0);
        add(0, 2'b10, 0, 32'h18, 0, 32'h1234_0006, 0);

        foreach (tbl[i]) begin
            model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].ad, tbl[i].wd, mrd, mer);
            xact_a(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].ad, tbl[i].wd, rd, er);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
        end

        for (int i = 0; i < 150; i++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [31:0] ad, wd;
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = $urandom;
            wd = $urandom;
            model(w, sz, u, ad, wd, mrd, mer);
            xact_a(w, sz, u, ad, wd, rd, er);
            check($sformatf("rnd%0d_rdata", i), rd, mrd);
            check($sformatf("rnd%0d_err", i), 32'(er), 32'(mer));
        end

        // Wait-state instance: lw 0x0C with response back-pressured for two cycles.
        check("b_ready_idle", 32'(b_req_ready), 32'd1);
        b_req_valid = 1; b_req_write = 0; b_req_size = 2'b10; b_req_addr = 32'h0C;
        @(posedge clk); #1;
        b_req_valid = 0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("b_wait%0d_valid", c), 32'(b_rsp_valid), 32'd0);
            check($sformatf("b_wait%0d_ready", c), 32'(b_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("b_valid_cycle4", 32'(b_rsp_valid), 32'd1);
        check("b_rdata", b_rsp_rdata, 32'h0000_0003);
        for (int c = 0; c < 2; c++) begin
            b_req_valid = 1; b_req_write = 1'($urandom); b_req_addr = $urandom; b_req_wdata = $urandom;
            @(posedge clk); #1;
            check("b_hold_valid", 32'(b_rsp_valid), 32'd1);
            check("b_hold_rdata", b_rsp_rdata, 32'h0000_0003);
            check("b_hold_ready", 32'(b_req_ready), 32'd0);
        end
        b_req_valid = 0;
        b_rsp_ready = 1;
        @(posedge clk); #1;
        b_rsp_ready = 0;
        check("b_done_valid", 32'(b_rsp_valid), 32'd0);
        check("b_done_ready", 32'(b_req_ready), 32'd1);

        // Store dropped by reset pulsed during the wait phase.
        b_req_valid = 1; b_req_write = 1; b_req_size = 2'b10; b_req_addr = 32'h18;
        b_req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        b_req_valid = 0;
        @(posedge clk); #1;
        b_rst = 1;
        #1;
        check("b_midrst_valid", 32'(b_rsp_valid), 32'd0);
        check("b_midrst_ready", 32'(b_req_ready), 32'd1);
        b_rst = 0;
        @(posedge clk); #1;
        check("b_postrst_valid", 32'(b_rsp_valid), 32'd0);
        b_req_valid = 1; b_req_write = 0; b_req_size = 2'b10; b_req_addr = 32'h18;
        @(posedge clk); #1;
        b_req_valid = 0;
        lat = 1;
        while (!b_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b_latency", 32'(lat), 32'd4);
        check("b_word6_kept", b_rsp_rdata, 32'h0000_0006);
        check("b_word6_err", 32'(b_rsp_err), 32'd0);
        b_rsp_ready = 1;
        @(posedge clk); #1;
        b_rsp_ready = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
